// File: rtl/global_controller_sequencer.sv
// global_controller_sequencer
//   Holds a per-object delay table and replays it into global_controller
//   on a fixed, paced schedule. It covers the boot load (boot_up +
//   input_valid strobes), holds table-parse mode, and runs incremental
//   scenario updates (glob_scen_noc_input_valid strobes for dirty entries,
//   then a scenario_update commit pulse).
//
// Ports
//   CLK, reset                 clock (rising edge), async active-low reset
//   cfg_we/cfg_addr/cfg_delay  table write port (sets valid; sets dirty
//                              outside the boot-load phase)
//   start_boot                 begin boot load (IDLE only)
//   start_update               begin scenario update (PARSE only)
//   stop_parse                 leave PARSE for IDLE (beats start_update)
//   boot_up, table_parse       mode levels to global_controller
//   input_valid                boot-phase element strobe
//   glob_scen_noc_input_valid  update-phase element strobe
//   delay_matrix_element       last issued delay (held between strobes)
//   obj_id_element             last issued object id (held between strobes)
//   scenario_update            one-cycle update commit
//   busy                       high in every state except IDLE and PARSE
module global_controller_sequencer #(
    parameter int N_obj        = 8,
    parameter int obj_id_width = 3,
    parameter int delay_length = 12,
    parameter int GAP          = 7,
    parameter int SETTLE       = 5
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [obj_id_width-1:0] cfg_addr,
    input  logic [delay_length-1:0] cfg_delay,
    input  logic                    start_boot,
    input  logic                    start_update,
    input  logic                    stop_parse,
    output logic                    boot_up,
    output logic                    table_parse,
    output logic                    input_valid,
    output logic                    glob_scen_noc_input_valid,
    output logic [delay_length-1:0] delay_matrix_element,
    output logic [obj_id_width-1:0] obj_id_element,
    output logic                    scenario_update,
    output logic                    busy
);

    typedef enum logic [2:0] {
        IDLE, BOOT_PRE, BOOT_ISSUE, BOOT_POST,
        PARSE, UPD_ISSUE, UPD_POST, UPD_COMMIT
    } state_t;

    // One down-counter serves both the settle windows and the post-issue gap.
    localparam int CMAX = (GAP > SETTLE) ? GAP : SETTLE;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0]           GAP_W    = CW'(GAP - 1);
    localparam logic [CW-1:0]           SETTLE_W = CW'(SETTLE - 1);
    localparam logic [obj_id_width-1:0] LAST     = obj_id_width'(N_obj - 1);

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [obj_id_width-1:0]   ptr;
    logic [delay_length-1:0]   tbl [N_obj];
    logic [N_obj-1:0]          vld;
    logic [N_obj-1:0]          dty;

    logic                      upd_mode;
    logic                      in_scan;
    logic                      scan_go;
    logic                      hit;
    logic                      mark;
    logic [obj_id_width-1:0]   scan_idx;
    logic [N_obj-1:0]          pick;

    // Outputs are registered, so an entry is "scanned" on the edge that
    // enters its scan cycle: the strobe is visible during that cycle.
    always_comb begin
        upd_mode = (state == PARSE) || (state == UPD_ISSUE);
        in_scan  = (state == BOOT_ISSUE) || (state == UPD_ISSUE);
        pick     = upd_mode ? dty : vld;
        scan_idx = in_scan ? ptr + 1'b1 : '0;
        scan_go  = ((state == BOOT_PRE) && (cnt == '0))
                || ((state == PARSE) && start_update && !stop_parse)
                || (in_scan && (cnt == '0) && (ptr != LAST));
        hit      = scan_go && pick[scan_idx];
        // Writes during the boot load are part of the initial image.
        mark     = !((state == IDLE) || (state == BOOT_PRE) || (state == BOOT_ISSUE));
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state                     <= IDLE;
            cnt                       <= '0;
            ptr                       <= '0;
            vld                       <= '0;
            dty                       <= '0;
            for (int i = 0; i < N_obj; i++) tbl[i] <= '0;
            boot_up                   <= 1'b0;
            table_parse               <= 1'b0;
            input_valid               <= 1'b0;
            glob_scen_noc_input_valid <= 1'b0;
            delay_matrix_element      <= '0;
            obj_id_element            <= '0;
            scenario_update           <= 1'b0;
            busy                      <= 1'b0;
        end else begin
            input_valid               <= 1'b0;
            glob_scen_noc_input_valid <= 1'b0;
            scenario_update           <= 1'b0;

            if (scan_go) begin
                ptr <= scan_idx;
                cnt <= hit ? GAP_W : '0;
                if (hit) begin
                    delay_matrix_element <= tbl[scan_idx];
                    obj_id_element       <= scan_idx;
                    if (upd_mode) begin
                        glob_scen_noc_input_valid <= 1'b1;
                        dty[scan_idx]             <= 1'b0;
                    end else begin
                        input_valid <= 1'b1;
                    end
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            // Transitions that load cnt are placed after the counter update
            // so they take precedence.
            case (state)
                IDLE: if (start_boot) begin
                    state   <= BOOT_PRE;
                    cnt     <= SETTLE_W;
                    boot_up <= 1'b1;
                    busy    <= 1'b1;
                end
                BOOT_PRE: if (cnt == '0) state <= BOOT_ISSUE;
                BOOT_ISSUE: if (cnt == '0 && ptr == LAST) begin
                    state <= BOOT_POST;
                    cnt   <= SETTLE_W;
                end
                BOOT_POST: if (cnt == '0) begin
                    state       <= PARSE;
                    boot_up     <= 1'b0;
                    table_parse <= 1'b1;
                    busy        <= 1'b0;
                end
                PARSE: if (stop_parse) begin
                    state       <= IDLE;
                    table_parse <= 1'b0;
                end else if (start_update) begin
                    state <= UPD_ISSUE;
                    busy  <= 1'b1;
                end
                UPD_ISSUE: if (cnt == '0 && ptr == LAST) begin
                    state <= UPD_POST;
                    cnt   <= SETTLE_W;
                end
                UPD_POST: if (cnt == '0) begin
                    state           <= UPD_COMMIT;
                    scenario_update <= 1'b1;
                end
                UPD_COMMIT: begin
                    state <= PARSE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Last so a write beats the dirty clear of an entry being issued.
            if (cfg_we) begin
                tbl[cfg_addr] <= cfg_delay;
                vld[cfg_addr] <= 1'b1;
                if (mark) dty[cfg_addr] <= 1'b1;
            end
        end
    end

endmodule
